// File: rtl/dec8_to_bin27.sv
// Converts 8 packed BCD digits to a 27-bit binary value, one digit per cycle, MSB first.
// Latency 8 cycles from the start edge to ok; st is ignored while busy. Optional macro: DEC8_TO_BIN27_ERR_EN.
module dec8_to_bin27 (
  input  logic        clk,
  input  logic        rst,
  input  logic        st,
  input  logic [31:0] DEC,
  output logic [26:0] BIN,
  output logic        ok,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state;
  logic [31:0] sr;
  logic [26:0] acc;
  logic [2:0]  cnt;
  logic [26:0] acc_nxt;

  // acc*10 built from two shifts; everything wraps modulo 2^27
  assign acc_nxt = (acc << 3) + (acc << 1) + {23'd0, sr[31:28]};

  assign busy = (state == CONV);
  assign ok   = (state == DONE);

`ifdef DEC8_TO_BIN27_ERR_EN
  logic bad;
  logic dec_bad;
  logic err_q;

  always_comb begin
    dec_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (DEC[i*4 +: 4] > 4'd9) dec_bad = 1'b1;
    end
  end

  assign err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && st) bad <= dec_bad;
      if (state == CONV && cnt == 3'd7) err_q <= bad;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      BIN   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (st) begin
            sr    <= DEC;
            acc   <= '0;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          acc <= acc_nxt;
          sr  <= {sr[27:0], 4'd0};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
`ifdef DEC8_TO_BIN27_ERR_EN
            BIN <= bad ? 27'd0 : acc_nxt;
`else
            BIN <= acc_nxt;
`endif
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
